timer_countdown: RTL and testbench

Sequential countdown timer. It holds an hours/minutes/seconds count and decrements it once per enabled one-second tick, borrowing across the s/m/h fields. It stops at 00:00:00, where it pulses a done flag and holds an expired level. It sits beside the wall-clock increment logic and shares its 6-bit h/m/s display fields.

---
 rtl/timer_countdown.sv | 109 ++++++++++
 tb/tb_timer_countdown.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_countdown.sv
// Countdown timer over h/m/s display fields. It decrements once per enabled tick,
// stops at 00:00:00, pulses done once, and holds expired until the next load.
module timer_countdown (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [5:0] set_h,
    input  logic [5:0] set_m,
    input  logic [5:0] set_s,
    output logic [5:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       running,
    output logic       expired,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t     state;
    logic [5:0] ld_h, ld_m, ld_s;
    logic [5:0] nx_h, nx_m, nx_s;
    logic       nx_zero, cnt_zero;

    // Clamp the presets so an out-of-range value can never enter the count.
    always_comb begin
        ld_h = (set_h > 6'd23) ? 6'd23 : set_h;
        ld_m = (set_m > 6'd59) ? 6'd59 : set_m;
        ld_s = (set_s > 6'd59) ? 6'd59 : set_s;
    end

    // One decrement step, borrowing from seconds to minutes to hours.
    always_comb begin
        nx_h = hour;
        nx_m = min;
        nx_s = sec;
        if (sec != 6'd0) begin
            nx_s = sec - 6'd1;
        end else if (min != 6'd0) begin
            nx_m = min - 6'd1;
            nx_s = 6'd59;
        end else if (hour != 6'd0) begin
            nx_h = hour - 6'd1;
            nx_m = 6'd59;
            nx_s = 6'd59;
        end
    end

    assign nx_zero  = (nx_h == 6'd0) && (nx_m == 6'd0) && (nx_s == 6'd0);
    assign cnt_zero = (hour == 6'd0) && (min == 6'd0) && (sec == 6'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            hour    <= 6'd0;
            min     <= 6'd0;
            sec     <= 6'd0;
            running <= 1'b0;
            expired <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                state   <= IDLE;
                hour    <= ld_h;
                min     <= ld_m;
                sec     <= ld_s;
                running <= 1'b0;
                expired <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!pause && start && !cnt_zero) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (tick) begin
                            hour <= nx_h;
                            min  <= nx_m;
                            sec  <= nx_s;
                            if (nx_zero) begin
                                state   <= DONE;
                                running <= 1'b0;
                                expired <= 1'b1;
                                done    <= 1'b1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (!pause && start) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    default: ; // DONE: only load or rst leaves
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_countdown.sv
// Directed bench for timer_countdown; each check compares {hour,min,sec,running,expired,done}
// against a hand-computed value one time unit after the active clock edge.
module tb_timer_countdown;

    logic       clk = 1'b0;
    logic       rst, tick, load, start, pause;
    logic [5:0] set_h, set_m, set_s;
    logic [5:0] hour, min, sec;
    logic       running, expired, done;
    logic [20:0] obs;
    int tests = 0;
    int fails = 0;

    timer_countdown dut (
        .clk(clk), .rst(rst), .tick(tick), .load(load), .start(start), .pause(pause),
        .set_h(set_h), .set_m(set_m), .set_s(set_s),
        .hour(hour), .min(min), .sec(sec),
        .running(running), .expired(expired), .done(done)
    );

    always #5 clk = ~clk;
    assign obs = {hour, min, sec, running, expired, done};

    task automatic cycle();
        @(posedge clk);
        #1;
        tick = 0; load = 0; start = 0; pause = 0;
    endtask

    task automatic do_load(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        set_h = h; set_m = m; set_s = s; load = 1;
        cycle();
    endtask

    task automatic test_reset();
        rst = 1; tick = 0; load = 0; start = 0; pause = 0;
        set_h = 0; set_m = 0; set_s = 0;
        #3;
        tests++;
        if (obs !== 21'h0) begin
            fails++; $display("FAIL reset got %h want %h", obs, 21'h0);
        end
        @(posedge clk); #1; rst = 0;
        cycle();
    endtask

    task automatic test_basic();
        do_load(6'd1, 6'd0, 6'd0);
        tests++;
        if (obs !== {6'd1, 6'd0, 6'd0, 3'b000}) begin
            fails++; $display("FAIL load_010000 got %h want %h", obs, {6'd1, 6'd0, 6'd0, 3'b000});
        end
        start = 1; cycle();
        tests++;
        if (obs !== {6'd1, 6'd0, 6'd0, 3'b100}) begin
            fails++; $display("FAIL start_running got %h want %h", obs, {6'd1, 6'd0, 6'd0, 3'b100});
        end
        tick = 1; cycle();
        tests++;
        if (obs !== {6'd0, 6'd59, 6'd59, 3'b100}) begin
            fails++; $display("FAIL hour_borrow got %h want %h", obs, {6'd0, 6'd59, 6'd59, 3'b100});
        end
    endtask

    task automatic test_expire();
        do_load(6'd0, 6'd0, 6'd2);
        start = 1; cycle();
        tick = 1; cycle();
        tests++;
        if (obs !== {6'd0, 6'd0, 6'd1, 3'b100}) begin
            fails++; $display("FAIL exp_step1 got %h want %h", obs, {6'd0, 6'd0, 6'd1, 3'b100});
        end
        tick = 1; cycle();
        tests++;
        if (obs !== {6'd0, 6'd0, 6'd0, 3'b011}) begin
            fails++; $display("FAIL exp_zero got %h want %h", obs, {6'd0, 6'd0, 6'd0, 3'b011});
        end
        cycle();
        tests++;
        if (obs !== {6'd0, 6'd0, 6'd0, 3'b010}) begin
            fails++; $display("FAIL done_one_cycle got %h want %h", obs, {6'd0, 6'd0, 6'd0, 3'b010});
        end
        for (int i = 0; i < 3; i++) begin
            tick = 1; start = 1; cycle();
            tests++;
            if (obs !== {6'd0, 6'd0, 6'd0, 3'b010}) begin
                fails++; $display("FAIL done_hold[%0d] got %h want %h", i, obs, {6'd0, 6'd0, 6'd0, 3'b010});
            end
        end
    endtask

    task automatic test_clamp();
        do_load(6'd30, 6'd63, 6'd60);
        tests++;
        if (obs !== {6'd23, 6'd59, 6'd59, 3'b000}) begin
            fails++; $display("FAIL clamp got %h want %h", obs, {6'd23, 6'd59, 6'd59, 3'b000});
        end
        start = 1; tick = 1; cycle();
        tests++;
        if (obs !== {6'd23, 6'd59, 6'd59, 3'b100}) begin
            fails++; $display("FAIL tick_on_start got %h want %h", obs, {6'd23, 6'd59, 6'd59, 3'b100});
        end
        tick = 1; cycle();
        tests++;
        if (obs !== {6'd23, 6'd59, 6'd58, 3'b100}) begin
            fails++; $display("FAIL clamp_dec got %h want %h", obs, {6'd23, 6'd59, 6'd58, 3'b100});
        end
        do_load(6'd0, 6'd1, 6'd0);
        start = 1; cycle();
        tick = 1; cycle();
        tests++;
        if (obs !== {6'd0, 6'd0, 6'd59, 3'b100}) begin
            fails++; $display("FAIL min_borrow got %h want %h", obs, {6'd0, 6'd0, 6'd59, 3'b100});
        end
        tick = 1; load = 1; set_h = 6'd2; set_m = 6'd3; set_s = 6'd4; cycle();
        tests++;
        if (obs !== {6'd2, 6'd3, 6'd4, 3'b000}) begin
            fails++; $display("FAIL load_beats_tick got %h want %h", obs, {6'd2, 6'd3, 6'd4, 3'b000});
        end
    endtask

    task automatic test_pause();
        do_load(6'd0, 6'd0, 6'd10);
        start = 1; cycle();
        pause = 1; tick = 1; cycle();
        tests++;
        if (obs !== {6'd0, 6'd0, 6'd10, 3'b000}) begin
            fails++; $display("FAIL pause_edge got %h want %h", obs, {6'd0, 6'd0, 6'd10, 3'b000});
        end
        for (int i = 0; i < 3; i++) begin
            tick = 1; cycle();
        end
        tests++;
        if (obs !== {6'd0, 6'd0, 6'd10, 3'b000}) begin
            fails++; $display("FAIL paused_ticks got %h want %h", obs, {6'd0, 6'd0, 6'd10, 3'b000});
        end
        start = 1; cycle();
        tick = 1; cycle();
        tests++;
        if (obs !== {6'd0, 6'd0, 6'd9, 3'b100}) begin
            fails++; $display("FAIL resume got %h want %h", obs, {6'd0, 6'd0, 6'd9, 3'b100});
        end
        start = 1; pause = 1; cycle();
        tick = 1; cycle();
        tests++;
        if (obs !== {6'd0, 6'd0, 6'd9, 3'b000}) begin
            fails++; $display("FAIL pause_wins got %h want %h", obs, {6'd0, 6'd0, 6'd9, 3'b000});
        end
        start = 1; cycle();
        for (int i = 0; i < 3; i++) begin
            tick = 1; cycle();
        end
        tests++;
        if (obs !== {6'd0, 6'd0, 6'd6, 3'b100}) begin
            fails++; $display("FAIL continuous_tick got %h want %h", obs, {6'd0, 6'd0, 6'd6, 3'b100});
        end
    endtask

    task automatic test_zero_start();
        int seen_done;
        seen_done = 0;
        do_load(6'd0, 6'd0, 6'd0);
        for (int i = 0; i < 4; i++) begin
            start = 1; tick = 1; cycle();
            if (done) seen_done++;
        end
        tests++;
        if (obs !== 21'h0 || seen_done != 0) begin
            fails++; $display("FAIL zero_start got %h done_seen %0d want %h done_seen 0", obs, seen_done, 21'h0);
        end
    endtask

    task automatic test_reset_mid();
        do_load(6'd0, 6'd5, 6'd0);
        start = 1; cycle();
        tests++;
        if (obs !== {6'd0, 6'd5, 6'd0, 3'b100}) begin
            fails++; $display("FAIL mid_run got %h want %h", obs, {6'd0, 6'd5, 6'd0, 3'b100});
        end
        #2 rst = 1;
        #1;
        tests++;
        if (obs !== 21'h0) begin
            fails++; $display("FAIL async_reset got %h want %h", obs, 21'h0);
        end
        #1 rst = 0;
        cycle();
        do_load(6'd0, 6'd0, 6'd3);
        tick = 1; cycle();
        tests++;
        if (obs !== {6'd0, 6'd0, 6'd3, 3'b000}) begin
            fails++; $display("FAIL idle_after_reset got %h want %h", obs, {6'd0, 6'd0, 6'd3, 3'b000});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_expire();
        test_clamp();
        test_pause();
        test_zero_start();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
